palette_loader: RTL
===================

// Module: palette_loader
// PURPOSE
//   Loads the 64-entry, 15-bit palette RAM used by the video output path from a byte stream
//   (SPI flash / OSD host), replacing the fixed power-on palette at runtime.
//   Arbitrates the RAM with the video read side: writes are issued only while blank=1,
//   i.e. outside the visible picture, so no visible pixel ever reads a half-updated entry.
// PARAMETERS
//   NUM_ENTRIES  64  palette entries per load; legal range 1..2**ADDR_W
//   ADDR_W       6   palette address width
// PORTS
//   clk        in   1       system clock; everything runs on this single clock
//   reset      in   1       synchronous, active-high; returns block to IDLE
//   start      in   1       1-cycle pulse: begin a load at entry 0; ignored unless IDLE
//   abort      in   1       cancel the load in progress; wins over start in the same cycle
//   in_data    in   8       stream byte: entry low byte first, then high byte
//   in_valid   in   1       in_data valid
//   in_ready   out  1       byte accepted on a cycle where in_valid && in_ready
//   blank      in   1       1 = video is not reading the palette this cycle
//   pal_we     out  1       palette RAM write strobe
//   pal_addr   out  ADDR_W  palette RAM write address
//   pal_wdata  out  15      {B[4:0],G[4:0],R[4:0]}
//   busy       out  1       1 in every state except IDLE
//   done       out  1       1-cycle pulse when the last entry is written
//   count      out  ADDR_W+1 entries written during the current/last load
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0, pal_we=0, pal_addr=0, pal_wdata=0, busy=0, done=0, count=0.
//   States:
//   - IDLE: in_ready=0. start && !abort -> LO; pal_addr<=0, count<=0.
//   - LO: in_ready=1. On accept, pal_wdata[7:0]<=in_data -> HI.
//   - HI: in_ready=1. On accept, pal_wdata[14:8]<=in_data[6:0] (bit 7 dropped) -> WR.
//   - WR: in_ready=0. pal_we = (state==WR) && blank, combinational, same cycle.
//     When blank=1, exactly one write cycle; count<=count+1.
//     If pal_addr==NUM_ENTRIES-1 -> DONE, pal_addr holds; else pal_addr<=pal_addr+1 -> LO.
//     While blank=0 the block stays in WR; address and data are held; the stream is stalled.
//   - DONE: done=1 for this single cycle -> IDLE. start is ignored in DONE.
//   Rules:
//   - pal_we is never high outside WR and never high while blank=0. One write per entry.
//   - pal_addr and pal_wdata are registered and stable for the whole time the block is in WR.
//   - abort, in any non-IDLE state -> IDLE next cycle. No pal_we in the abort cycle, no done pulse.
//     count keeps the number of entries already written; RAM entries below count stay updated.
//   - start while busy has no effect. reset mid-load behaves like abort, and count is cleared.
//   - Byte accept: in_ready is a function of state only, so it never depends on in_valid.
//     An in_valid byte offered while in_ready=0 is not consumed, and the source must hold it.
//   - Throughput with blank=1 throughout: 3 cycles per entry (LO, HI, WR).
//     A 64-entry load takes 192 cycles from the first byte, plus the DONE cycle.
// TESTING
//   1 start, 128 bytes always valid, blank=1 -> 64 pal_we pulses at addr 0..63,
//     done pulses once, count=64, busy low the cycle after done.
//   2 entry bytes 0x1F,0x80 -> pal_wdata=15'h001F (bit 15 dropped);
//     bytes 0xE0,0x7F -> pal_wdata=15'h7FE0.
//   3 blank=0 for 100 cycles while in WR -> pal_we=0, in_ready=0, addr/data held;
//     blank rises -> one write on that same cycle.
//   4 abort after 10 entries -> IDLE next cycle, no done, count=10, in_ready=0;
//     a new start reloads from addr 0.
//   5 start pulsed mid-load -> ignored, addresses continue in sequence;
//     start+abort in the same cycle while IDLE -> stays IDLE.
//   6 reset asserted in HI state -> all outputs at reset values next cycle;
//     NUM_ENTRIES=4 build -> done after addr 3.

Source files
------------

// File: rtl/palette_loader_if.sv
// Byte-stream and palette-RAM write signals shared by the loader and its host.
// The master side drives the stream/control inputs; the slave side is the loader.
interface palette_loader_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              abort;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              blank;
   logic              pal_we;
   logic [ADDR_W-1:0] pal_addr;
   logic [14:0]       pal_wdata;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   count;

   modport master (
      output start, abort, in_data, in_valid, blank,
      input  in_ready, pal_we, pal_addr, pal_wdata, busy, done, count
   );

   modport slave (
      input  start, abort, in_data, in_valid, blank,
      output in_ready, pal_we, pal_addr, pal_wdata, busy, done, count
   );
endinterface

// File: rtl/palette_loader.sv
// Streams lo/hi byte pairs into the palette RAM, 3 cycles per entry; writes only while blank=1.
// Backpressure: in_ready depends on state only; the stream stalls while an entry waits for blank.
module palette_loader #(
   parameter int NUM_ENTRIES = 64,
   parameter int ADDR_W      = 6
) (
   input  logic            i_clk,
   input  logic            i_reset,
   palette_loader_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [14:0]       r_wdata;
   logic [ADDR_W:0]   r_count;
   logic              w_in_ready;
   logic              w_we;
   logic              w_last;
   logic              w_accept_lo;
   logic              w_accept_hi;
   logic              w_launch;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_we       = 1'b0;
      w_last     = (r_addr == LAST_ADDR);
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               w_next = S_LO;
            end
         end
         S_LO: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_next = S_HI;
            end
         end
         S_HI: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_next = S_WR;
            end
         end
         S_WR: begin
            // Hold address and data until the video side stops reading.
            w_we = bus.blank;
            if (bus.blank) begin
               w_next = w_last ? S_DONE : S_LO;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
      if (bus.abort && (r_state != S_IDLE)) begin
         w_next = S_IDLE;
         w_we   = 1'b0;
      end
   end

   assign w_launch    = (r_state == S_IDLE) && bus.start && !bus.abort;
   assign w_accept_lo = (r_state == S_LO) && bus.in_valid && !bus.abort;
   assign w_accept_hi = (r_state == S_HI) && bus.in_valid && !bus.abort;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_count <= '0;
      end else begin
         if (w_launch) begin
            r_addr  <= '0;
            r_count <= '0;
         end
         if (w_accept_lo) begin
            r_wdata[7:0] <= bus.in_data;
         end
         // Colour is 15 bits; the top bit of the high byte has no home.
         if (w_accept_hi) begin
            r_wdata[14:8] <= bus.in_data[6:0];
         end
         if (w_we) begin
            r_count <= r_count + COUNT_ONE;
            if (!w_last) begin
               r_addr <= r_addr + ADDR_ONE;
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.pal_we    = w_we;
   assign bus.pal_addr  = r_addr;
   assign bus.pal_wdata = r_wdata;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE) && !bus.abort;
   assign bus.count     = r_count;

   a_we_only_in_blank: assert property (@(posedge i_clk) disable iff (i_reset)
      bus.pal_we |-> (bus.blank && (r_state == S_WR) && !bus.abort));

   a_ready_not_idle: assert property (@(posedge i_clk) disable iff (i_reset)
      bus.in_ready |-> ((r_state == S_LO) || (r_state == S_HI)));
endmodule
